// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and the ALU control decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALUOP_RTYPE = 3'b111;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b011;
  localparam logic [2:0] ALUOP_IDLE  = 3'b000;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [2:0] {K_R, K_J, K_LW, K_SW, K_IMM} op_kind_e;
  typedef enum logic [1:0] {IC_ADD = 2'd0, IC_OR = 2'd1, IC_LUI = 2'd2} imm_class_e;

  typedef struct packed {
    op_kind_e   kind;
    imm_class_e iclass;
    logic       legal;
  } op_info_t;

  function automatic logic [2:0] imm_aluop(input imm_class_e c);
    case (c)
      IC_OR:   return ALUOP_OR;
      IC_LUI:  return ALUOP_LUI;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: instruction kind, I-type sub-op and legality.
module ctrl_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_info_t   info_o
);

  always_comb begin
    info_o = '0;
    case (opcode_i)
      OP_R:    begin info_o.kind = K_R;   info_o.legal = 1'b1; end
      OP_J:    begin info_o.kind = K_J;   info_o.legal = 1'b1; end
      OP_LW:   begin info_o.kind = K_LW;  info_o.legal = 1'b1; end
      OP_SW:   begin info_o.kind = K_SW;  info_o.legal = 1'b1; end
      OP_ADDI: begin info_o.kind = K_IMM; info_o.iclass = IC_ADD; info_o.legal = 1'b1; end
      OP_ORI:  begin info_o.kind = K_IMM; info_o.iclass = IC_OR;  info_o.legal = 1'b1; end
      OP_LUI:  begin info_o.kind = K_IMM; info_o.iclass = IC_LUI; info_o.legal = 1'b1; end
      default: info_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with Moore datapath controls.
// MEM_WAIT_EN adds a mem_ready handshake that stalls FETCH/MEM_READ/MEM_WRITE.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  imm_class_e iclass_q, iclass_d;
  logic       store_q, store_d;
  logic       illegal_q, illegal_d;
  logic       rdy;
  op_info_t   dec;

`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  ctrl_opcode_decode u_dec (
    .opcode_i (opcode),
    .info_o   (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      iclass_q  <= IC_ADD;
      store_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iclass_q  <= iclass_d;
      store_q   <= store_d;
      illegal_q <= illegal_d;
    end
  end

  // Sub-op and load/store are captured in DECODE so later opcode changes are harmless.
  always_comb begin
    iclass_d  = iclass_q;
    store_d   = store_q;
    illegal_d = 1'b0;
    if (state_q == S_DECODE) begin
      iclass_d  = dec.iclass;
      store_d   = (dec.kind == K_SW);
      illegal_d = !dec.legal;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_IDLE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_source  = PCSRC_ALU;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = rdy;
        pc_write  = rdy;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!dec.legal) state_d = S_FETCH;
        else begin
          case (dec.kind)
            K_LW, K_SW: state_d = S_MEM_ADDR;
            K_R:        state_d = S_R_EXEC;
            K_IMM:      state_d = S_I_EXEC;
            K_J:        state_d = S_JUMP;
            default:    state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = store_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_aluop(iclass_q);
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: an instruction program is expanded into per-cycle expected outputs.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       iod, mr, mw, irw, pcw, rw, rd, m2r;
    logic [1:0] pcs;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic       rst;
    logic       rdy;
    exp_t       e;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'b0;
`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif
  logic [2:0] alu_op;
  logic       alu_src_a, i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] state;
  logic [20:0] act;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {state, alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
                ir_write, pc_write, reg_write, reg_dst, mem_to_reg, pc_source, illegal_op};

  rec_t prog[$];
  rec_t cur;
  bit   have = 1'b0;
  bit   pend_ill = 1'b0;
  int   errors = 0, checks = 0, cyc = 0;
  int   ill_cnt = 0, rw_cnt = 0, pcw_cnt = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Output table by state number, straight from the control-signal list.
  function automatic exp_t exp_out(input int st, input logic [2:0] iaop, input bit rdy);
    exp_t e;
    e = '0;
    e.st = st[3:0];
    case (st)
      1:  begin e.mr = 1; e.irw = rdy; e.pcw = rdy; e.sb = 2'b01; e.aop = 3'b100; end
      3:  begin e.sa = 1; e.sb = 2'b10; e.aop = 3'b100; end
      4:  begin e.mr = 1; e.iod = 1; end
      5:  begin e.rw = 1; e.m2r = 1; end
      6:  begin e.mw = 1; e.iod = 1; end
      7:  begin e.sa = 1; e.aop = 3'b111; end
      8:  begin e.rw = 1; e.rd = 1; end
      9:  begin e.sa = 1; e.sb = 2'b10; e.aop = iaop; end
      10: e.rw = 1;
      11: begin e.pcw = 1; e.pcs = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  // Appends one instruction's cycles; opcode switches to chg after DECODE,
  // reset is driven in sequence step rst_at, fst/mst are memory stall cycles.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] chg, input int rst_at,
                            input int fst, input int mst, output int n);
    int seq[$];
    logic [2:0] ia;
    bit legal, first, stop;
    rec_t r;
    legal = 1; ia = 3'b000;
    case (op)
      6'b000000: seq = '{1, 2, 7, 8};
      6'b000010: seq = '{1, 2, 11};
      6'b100011: seq = '{1, 2, 3, 4, 5};
      6'b101011: seq = '{1, 2, 3, 6};
      6'b001000: begin seq = '{1, 2, 9, 10}; ia = 3'b100; end
      6'b001101: begin seq = '{1, 2, 9, 10}; ia = 3'b101; end
      6'b001111: begin seq = '{1, 2, 9, 10}; ia = 3'b011; end
      default:   begin seq = '{1, 2}; legal = 0; end
    endcase
    n = 0; first = 1; stop = 0;
    for (int i = 0; i < seq.size() && !stop; i++) begin
      int ns;
      ns = (seq[i] == 1) ? fst : ((seq[i] == 4 || seq[i] == 6) ? mst : 0);
      for (int k = 0; k <= ns; k++) begin
        r.op  = (i >= 2) ? chg : op;
        r.rst = (i == rst_at);
        r.rdy = (k == ns);
        r.e   = exp_out(seq[i], ia, r.rdy);
        if (first && pend_ill) r.e.ill = 1'b1;
        first = 0;
        prog.push_back(r);
        n++;
      end
      if (i == rst_at) begin
        r.op = 6'b0; r.rst = 0; r.rdy = 1;
        r.e = exp_out(0, 3'b000, 1'b1);
        prog.push_back(r);
        n++;
        stop = 1;
      end
    end
    pend_ill = stop ? 1'b0 : !legal;
  endtask

  always @(negedge clk) begin
    if (have) begin
      chk($sformatf("cyc%0d st%0d outputs", cyc, cur.e.st), int'(act), int'(cur.e));
      chk("rd_wr_excl", int'(mem_read & mem_write), 0);
      chk("rw_pcw_excl", int'(reg_write & pc_write), 0);
      ill_cnt += int'(illegal_op);
      rw_cnt  += int'(reg_write);
      pcw_cnt += int'(pc_write);
      cyc++;
    end
  end

  initial begin
    rec_t r;
    int n;
    for (int i = 0; i < 3; i++) begin
      r = '0; r.rst = (i < 2); r.rdy = 1; r.e = exp_out(0, 3'b000, 1'b1);
      prog.push_back(r);
    end
    push_instr(6'b000000, 6'b000000, -1, 0, 0, n); chk("lat_R", n, 4);
    push_instr(6'b100011, 6'b100011, -1, 0, 0, n); chk("lat_LW", n, 5);
    push_instr(6'b001101, 6'b001111, -1, 0, 0, n); chk("lat_ORI", n, 4);
    push_instr(6'b001111, 6'b001111, -1, 0, 0, n);
    push_instr(6'b001000, 6'b001000, -1, 0, 0, n);
    push_instr(6'b101011, 6'b101011, -1, 0, 0, n); chk("lat_SW", n, 4);
    push_instr(6'b000010, 6'b000010, -1, 0, 0, n); chk("lat_J", n, 3);
    push_instr(6'b111111, 6'b111111, -1, 0, 0, n); chk("lat_ill", n, 2);
    push_instr(6'b010101, 6'b010101, -1, 0, 0, n);
    push_instr(6'b000000, 6'b000000, -1, 0, 0, n);
    push_instr(6'b101011, 6'b101011, 3, 0, 0, n);  chk("lat_SW_rst", n, 5);
    push_instr(6'b000010, 6'b000010, -1, 0, 0, n);
`ifdef MEM_WAIT_EN
    push_instr(6'b001000, 6'b001000, -1, 2, 0, n); chk("lat_ADDI_stall", n, 6);
    push_instr(6'b100011, 6'b100011, -1, 0, 1, n); chk("lat_LW_stall", n, 6);
`endif
    while (prog.size() > 0) begin
      @(posedge clk);
      #1;
      cur = prog.pop_front();
      opcode = cur.op;
      reset  = cur.rst;
`ifdef MEM_WAIT_EN
      mem_ready = cur.rdy;
`endif
      have = 1'b1;
    end
    @(negedge clk);
    #1;
    have = 1'b0;
    chk("illegal_pulses", ill_cnt, 2);
`ifdef MEM_WAIT_EN
    chk("reg_write_cycles", rw_cnt, 8);
    chk("pc_write_cycles", pcw_cnt, 16);
`else
    chk("reg_write_cycles", rw_cnt, 6);
    chk("pc_write_cycles", pcw_cnt, 14);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
